matrix_entry_ctrl: RTL and testbench
====================================

# matrix_entry_ctrl

Keypad entry controller for the matrix calculator front end. It consumes the registered keypad strobe/code stream and classifies each key as a digit or a command. It accumulates up to two decimal digits plus a sign into one signed matrix element, then sequences a one-cycle write of each element into the operand register file, element by element, until the matrix is full. It sits between the keypad scanner and the operand matrix storage, and it is the only writer of that storage during entry.

## Interface
- N_ELEM, 4, number of elements per matrix (row-major); minimum 2
- ADDR_W, 2, element address width; must satisfy 2**ADDR_W >= N_ELEM
- clk  input  1  system clock, all state on rising edge
- nrst  input  1  asynchronous active-low reset
- keystrobe  input  1  one-cycle pulse, keycode valid this cycle
- keycode  input  4  0–9 digit; 0xA ENTER; 0xB CLEAR; 0xC NEGATE; 0xD ABORT; 0xE/0xF ignored
- start  input  1  one-cycle pulse, begin entry of a new matrix
- wr_en  output  1  element write strobe to operand storage
- wr_addr  output  ADDR_W  element index being written
- wr_data  output  8  signed two's-complement element value
- cur_val  output  8  signed value currently being typed (display)
- digit_cnt  output  2  digits accepted for the current element (0–2)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, all N_ELEM elements written
- aborted  output  1  one-cycle pulse, entry cancelled by ABORT

## Operation
- States: IDLE, ENTRY, WRITE, DONE. Registers: state, acc (7-bit unsigned, max 99), cnt (2-bit), neg (1-bit), addr (ADDR_W).
- IDLE: start=1 → ENTRY; acc, cnt, neg and addr are cleared to 0. All keystrobes are ignored.
- ENTRY (acts only when keystrobe=1):
  - Digit d with cnt<2: acc ← acc*10+d, cnt ← cnt+1. Digit with cnt==2 is dropped; no change.
  - CLEAR: acc, cnt, neg ← 0.
  - NEGATE: neg ← ~neg. Allowed at any cnt.
  - ENTER: → WRITE. This is legal with cnt==0, which writes value 0.
  - ABORT: → IDLE and aborted pulses. Elements already written stay in storage; done does not assert.
  - 0xE/0xF: no effect.
- WRITE (exactly one cycle):
  - wr_en=1, wr_addr=addr, wr_data = neg ? −acc : acc (8-bit two's complement). neg with acc==0 yields 0x00.
  - Next state: if addr==N_ELEM−1 → DONE. Otherwise addr ← addr+1, acc/cnt/neg ← 0, → ENTRY.
- DONE (one cycle): done=1, then → IDLE. addr is held at its last value until the next start.
- Output assignments:
  - cur_val = neg ? −acc : acc in every state.
  - digit_cnt = cnt.
  - wr_data holds its last written value when wr_en=0.
- Keystrobes in WRITE or DONE are discarded; they are not queued.
- start outside IDLE is ignored, including a start coinciding with an ABORT.

## Timing
- Reset (nrst=0, asynchronous): state=IDLE, and all registers cleared. wr_en=0, wr_addr=0, wr_data=0x00, cur_val=0x00, digit_cnt=0, busy=0, done=0, aborted=0.
- Reset mid-entry or mid-write: immediate return to IDLE. A wr_en in progress drops combinationally with reset.
- A keystrobe sampled at edge k updates acc/cnt/neg/state, visible after edge k.
- ENTER at edge k: wr_en is high for the cycle after edge k, for exactly 1 cycle.
- Last ENTER at edge k: wr_en in cycle k+1, done in cycle k+2, busy=0 from cycle k+3.
- aborted is high for the cycle following the ABORT edge, with busy already 0.
- Minimum spacing between keystrobes is 1 cycle. The strobe immediately following an ENTER falls into WRITE and is lost; the keypad scanner guarantees spacing ≥2.
- done, aborted and wr_en are Moore outputs decoded from state, so they are glitch-free registered-state decodes.

## Test plan
- Reset then idle: nrst low mid-ENTRY with acc=5 → all outputs at reset values; a keystrobe with keycode 3 while IDLE leaves cur_val=0.
- Full 2x2 entry: start; keys 1,2,ENTER; 7,ENTER; C,4,5,ENTER; ENTER → writes (0,0x0C), (1,0x07), (2,0xD3), (3,0x00). done pulses 1 cycle after the last wr_en; busy then 0.
- Digit saturation and clear: keys 9,9,9 → cur_val=99, digit_cnt=2. Then B → cur_val=0, digit_cnt=0. Then 3, ENTER → wr_data=0x03.
- Sign handling: C,C,8,ENTER → 0x08; C,ENTER → 0x00; 9,9,C,ENTER → 0x9D (−99).
- Abort: after 2 elements written, key D → aborted 1 cycle, busy 0, no done. A new start restarts at wr_addr=0.
- Ignored events: start during ENTRY → addr unchanged; keys E/F → no change. A keystrobe in the WRITE cycle → not applied; the next element starts at acc=0.

Source files
------------

// File: rtl/matrix_entry_ctrl.sv
// matrix_entry_ctrl
// Keypad entry controller for the matrix calculator front end. Builds one
// signed element from up to two decimal digits plus a sign, then writes it
// into the operand register file. This repeats element by element until all
// N_ELEM elements have been written.
//
// Ports
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   keystrobe  one-cycle pulse, keycode valid
//   keycode    0-9 digit, A enter, B clear, C negate, D abort, E/F ignored
//   start      one-cycle pulse, begin entry of a new matrix
//   wr_en      element write strobe (one cycle per element)
//   wr_addr    element index being written
//   wr_data    signed element value, holds last written value
//   cur_val    signed value being typed (display)
//   digit_cnt  digits accepted for the current element
//   busy       high outside IDLE
//   done       one-cycle pulse after the last element is written
//   aborted    one-cycle pulse after an ABORT key
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start, keys ignored
// S_ENTRY | accumulating digits/sign for element addr
// S_WRITE | one-cycle write of the current element
// S_DONE  | one-cycle completion pulse, then back to idle
module matrix_entry_ctrl #(
   parameter int N_ELEM = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              keystrobe,
   input  logic [3:0]        keycode,
   input  logic              start,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [7:0]        cur_val,
   output logic [1:0]        digit_cnt,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_CLEAR  = 4'hB;
   localparam logic [3:0] KEY_NEGATE = 4'hC;
   localparam logic [3:0] KEY_ABORT  = 4'hD;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEM - 1);

   state_t            state, state_nxt;
   logic [6:0]        acc, acc_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic              neg, neg_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic              aborted_q, aborted_nxt;
   logic [7:0]        wr_data_q;

   logic [6:0]        acc_x10;
   logic [7:0]        mag;
   logic [7:0]        signed_val;

   // acc is at most 9 whenever a second digit is accepted, so 7 bits suffice
   assign acc_x10    = 7'((acc << 3) + (acc << 1));
   assign mag        = {1'b0, acc};
   assign signed_val = neg ? 8'(~mag + 8'd1) : mag;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         acc       <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         addr      <= '0;
         aborted_q <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         cnt       <= cnt_nxt;
         neg       <= neg_nxt;
         addr      <= addr_nxt;
         aborted_q <= aborted_nxt;
         if (state == S_WRITE)
            wr_data_q <= signed_val;
      end
   end

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      neg_nxt     = neg;
      addr_nxt    = addr;
      aborted_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ENTRY;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               neg_nxt   = 1'b0;
               addr_nxt  = '0;
            end
         end
         S_ENTRY: begin
            if (keystrobe) begin
               if (keycode <= 4'd9) begin
                  if (cnt < 2'd2) begin
                     acc_nxt = 7'(acc_x10 + {3'b000, keycode});
                     cnt_nxt = 2'(cnt + 2'd1);
                  end
               end else if (keycode == KEY_ENTER) begin
                  state_nxt = S_WRITE;
               end else if (keycode == KEY_CLEAR) begin
                  acc_nxt = '0;
                  cnt_nxt = '0;
                  neg_nxt = 1'b0;
               end else if (keycode == KEY_NEGATE) begin
                  neg_nxt = ~neg;
               end else if (keycode == KEY_ABORT) begin
                  state_nxt   = S_IDLE;
                  aborted_nxt = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (addr == LAST_ADDR) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_ENTRY;
               addr_nxt  = ADDR_W'(addr + 1'b1);
               acc_nxt   = '0;
               cnt_nxt   = '0;
               neg_nxt   = 1'b0;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign wr_en     = (state == S_WRITE);
   assign wr_addr   = addr;
   assign wr_data   = wr_en ? signed_val : wr_data_q;
   assign cur_val   = signed_val;
   assign digit_cnt = cnt;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
module tb_matrix_entry_ctrl;

   logic       clk;
   logic       nrst;
   logic       keystrobe;
   logic [3:0] keycode;
   logic       start;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] cur_val;
   logic [1:0] digit_cnt;
   logic       busy;
   logic       done;
   logic       aborted;

   int checks   = 0;
   int failures = 0;

   matrix_entry_ctrl #(.N_ELEM(4), .ADDR_W(2)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .keystrobe (keystrobe),
      .keycode   (keycode),
      .start     (start),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cur_val   (cur_val),
      .digit_cnt (digit_cnt),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // all drive/sample points sit 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      keystrobe = 1'b1;
      keycode   = k;
      tick();
      keystrobe = 1'b0;
      keycode   = 4'h0;
   endtask

   // key followed by a spacing cycle
   task automatic key(input logic [3:0] k);
      press(k);
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // ENTER, then check the write cycle, then step out of WRITE
   task automatic enter_chk(input string tag, input logic [1:0] a, input logic [7:0] d);
      press(4'hA);
      chk({tag, "_wr_en"}, 8'(wr_en), 8'h01);
      chk({tag, "_wr_addr"}, 8'(wr_addr), 8'(a));
      chk({tag, "_wr_data"}, wr_data, d);
      tick();
   endtask

   initial begin
      nrst      = 1'b0;
      keystrobe = 1'b0;
      keycode   = 4'h0;
      start     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;
      tick();

      // reset mid-entry
      pulse_start();
      key(4'd5);
      chk("pre_rst_cur_val", cur_val, 8'h05);
      nrst = 1'b0;
      #2;
      chk("rst_wr_en", 8'(wr_en), 8'h00);
      chk("rst_wr_addr", 8'(wr_addr), 8'h00);
      chk("rst_wr_data", wr_data, 8'h00);
      chk("rst_cur_val", cur_val, 8'h00);
      chk("rst_digit_cnt", 8'(digit_cnt), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_done", 8'(done), 8'h00);
      chk("rst_aborted", 8'(aborted), 8'h00);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      tick();
      key(4'd3);
      chk("idle_key_cur_val", cur_val, 8'h00);
      chk("idle_key_busy", 8'(busy), 8'h00);

      // full 2x2 entry
      pulse_start();
      chk("start_busy", 8'(busy), 8'h01);
      key(4'd1);
      key(4'd2);
      chk("e0_cur_val", cur_val, 8'h0C);
      chk("e0_digit_cnt", 8'(digit_cnt), 8'h02);
      enter_chk("e0", 2'd0, 8'h0C);
      chk("e0_wr_en_drop", 8'(wr_en), 8'h00);
      chk("e0_wr_data_hold", wr_data, 8'h0C);
      chk("e1_cur_val_clr", cur_val, 8'h00);
      key(4'd7);
      enter_chk("e1", 2'd1, 8'h07);
      key(4'hC);
      key(4'd4);
      key(4'd5);
      chk("e2_cur_val", cur_val, 8'hD3);
      enter_chk("e2", 2'd2, 8'hD3);
      press(4'hA);
      chk("e3_wr_en", 8'(wr_en), 8'h01);
      chk("e3_wr_addr", 8'(wr_addr), 8'h03);
      chk("e3_wr_data", wr_data, 8'h00);
      chk("e3_done_early", 8'(done), 8'h00);
      tick();
      chk("done_pulse", 8'(done), 8'h01);
      chk("done_wr_en", 8'(wr_en), 8'h00);
      chk("done_busy", 8'(busy), 8'h01);
      tick();
      chk("done_end", 8'(done), 8'h00);
      chk("idle_busy", 8'(busy), 8'h00);
      chk("idle_addr_held", 8'(wr_addr), 8'h03);

      // saturation, clear, then sign handling
      pulse_start();
      chk("restart_addr", 8'(wr_addr), 8'h00);
      key(4'd9);
      key(4'd9);
      key(4'd9);
      chk("sat_cur_val", cur_val, 8'h63);
      chk("sat_digit_cnt", 8'(digit_cnt), 8'h02);
      key(4'hB);
      chk("clr_cur_val", cur_val, 8'h00);
      chk("clr_digit_cnt", 8'(digit_cnt), 8'h00);
      key(4'd3);
      enter_chk("s0", 2'd0, 8'h03);
      key(4'hC);
      key(4'hC);
      key(4'd8);
      enter_chk("s1", 2'd1, 8'h08);
      key(4'hC);
      enter_chk("s2", 2'd2, 8'h00);
      key(4'd9);
      key(4'd9);
      key(4'hC);
      enter_chk("s3", 2'd3, 8'h9D);
      chk("s_done", 8'(done), 8'h01);
      tick();

      // ignored events and abort
      pulse_start();
      key(4'd1);
      enter_chk("a0", 2'd0, 8'h01);
      pulse_start();
      chk("start_in_entry_addr", 8'(wr_addr), 8'h01);
      key(4'd2);
      key(4'hE);
      key(4'hF);
      chk("ef_cur_val", cur_val, 8'h02);
      chk("ef_digit_cnt", 8'(digit_cnt), 8'h01);
      press(4'hA);
      chk("a1_wr_data", wr_data, 8'h02);
      press(4'd7);
      chk("wr_key_cur_val", cur_val, 8'h00);
      chk("wr_key_digit_cnt", 8'(digit_cnt), 8'h00);
      chk("wr_key_addr", 8'(wr_addr), 8'h02);
      tick();
      start = 1'b1;
      press(4'hD);
      start = 1'b0;
      chk("abort_pulse", 8'(aborted), 8'h01);
      chk("abort_busy", 8'(busy), 8'h00);
      chk("abort_done", 8'(done), 8'h00);
      tick();
      chk("abort_end", 8'(aborted), 8'h00);
      chk("abort_start_ignored", 8'(busy), 8'h00);
      pulse_start();
      chk("post_abort_addr", 8'(wr_addr), 8'h00);
      key(4'd6);
      enter_chk("p0", 2'd0, 8'h06);
      key(4'hD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
